// File: rtl/axil_imem_rd_slv_pkg.sv
// Shared types and constants for the instruction-memory AXI-lite read responder.
package axil_imem_rd_slv_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned LAT_W      = 8;
  localparam int unsigned LFSR_W     = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    WAIT_LAT = 3'b010,
    RESP     = 3'b100
  } state_e;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [RESP_W-1:0]     resp;
  } r_beat_t;

  // Fibonacci step, taps 8,6,5,4
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/axil_lat_lfsr.sv
// Free-running 8-bit LFSR producing a pseudo-random response latency in 0..MAX_LAT.
module axil_lat_lfsr
  import axil_imem_rd_slv_pkg::*;
#(
  parameter int unsigned MAX_LAT = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [LAT_W-1:0] lat_c
);

  logic [LFSR_W-1:0] lfsr_q;

  // Advances every cycle so latency depends on when the request arrives
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lat_c = LAT_W'(lfsr_q[2:0] & 3'(MAX_LAT));

endmodule

// File: rtl/axil_imem_rd_slv.sv
// AXI-lite read responder for instruction fetch, backed by a backdoor-loaded word array.
module axil_imem_rd_slv
  import axil_imem_rd_slv_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned           DEPTH     = 4096,
  parameter int unsigned           LATENCY   = 2,
  parameter int unsigned           RAND_LAT  = 0,
  parameter int unsigned           MAX_LAT   = 7,
  localparam int unsigned          IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_ar_valid_i,
  input  logic [AXI_ADDR_W-1:0] slv_ar_addr_i,
  output logic                  slv_ar_ready_o,
  output logic                  slv_r_valid_o,
  output logic [AXI_DATA_W-1:0] slv_r_data_o,
  output logic [RESP_W-1:0]     slv_r_resp_o,
  input  logic                  slv_r_ready_i,
  input  logic                  ld_en_i,
  input  logic [IDX_W-1:0]      ld_addr_i,
  input  logic [AXI_DATA_W-1:0] ld_data_i
);

  localparam logic [AXI_ADDR_W:0] END_ADDR =
    (AXI_ADDR_W+1)'(BASE_ADDR) + (AXI_ADDR_W+1)'(DEPTH) * (AXI_ADDR_W+1)'(4);

  state_e                state_q;
  logic [LAT_W-1:0]      cnt_q;
  logic [LAT_W-1:0]      rnd_lat;
  logic [LAT_W-1:0]      lat_sel;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_ADDR_W-1:0] addr_sel;
  logic [AXI_ADDR_W-1:0] addr_off;
  r_beat_t               beat_c;
  logic                  ar_hs;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  if (RAND_LAT != 0) begin : g_rand
    axil_lat_lfsr #(.MAX_LAT(MAX_LAT)) u_lat (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .lat_c (rnd_lat)
    );
  end else begin : g_fix
    assign rnd_lat = '0;
  end

  assign lat_sel = (RAND_LAT != 0) ? (rnd_lat & LAT_W'(MAX_LAT)) : LAT_W'(LATENCY);
  assign ar_hs   = slv_ar_valid_i & slv_ar_ready_o;

  // Zero-latency requests decode straight from the AR bus; others from the latched address
  assign addr_sel = (state_q == IDLE) ? slv_ar_addr_i : addr_q;
  assign addr_off = addr_sel - BASE_ADDR;

  // Response decode: misalignment wins over out-of-range
  always_comb begin
    beat_c.data = '0;
    beat_c.resp = RESP_OKAY;
    if (addr_sel[1:0] != 2'b00) begin
      beat_c.resp = RESP_SLVERR;
    end else if ((addr_sel < BASE_ADDR) || ({1'b0, addr_sel} >= END_ADDR)) begin
      beat_c.resp = RESP_DECERR;
    end else begin
      beat_c.data = mem[IDX_W'(addr_off >> 2)];
    end
  end

  // Backdoor load; contents survive reset
  always_ff @(posedge clk_i) begin
    if (ld_en_i) mem[ld_addr_i] <= ld_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      slv_ar_ready_o <= 1'b0;
      slv_r_valid_o  <= 1'b0;
      slv_r_data_o   <= '0;
      slv_r_resp_o   <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          slv_ar_ready_o <= 1'b1;
          if (ar_hs) begin
            slv_ar_ready_o <= 1'b0;
            addr_q         <= slv_ar_addr_i;
            if (lat_sel == '0) begin
              state_q       <= RESP;
              slv_r_valid_o <= 1'b1;
              slv_r_data_o  <= beat_c.data;
              slv_r_resp_o  <= beat_c.resp;
            end else begin
              cnt_q   <= lat_sel;
              state_q <= WAIT_LAT;
            end
          end
        end
        WAIT_LAT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            state_q       <= RESP;
            slv_r_valid_o <= 1'b1;
            slv_r_data_o  <= beat_c.data;
            slv_r_resp_o  <= beat_c.resp;
          end
        end
        RESP: begin
          // Beat stays frozen until accepted; AR reopens the following cycle
          if (slv_r_ready_i) begin
            state_q        <= IDLE;
            slv_r_valid_o  <= 1'b0;
            slv_ar_ready_o <= 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          slv_ar_ready_o <= 1'b0;
          slv_r_valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_imem_rd_slv.sv
// Bench for axil_imem_rd_slv: fixed-latency instance plus a random-latency instance.
module tb_axil_imem_rd_slv;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ar_valid [2];
  logic [31:0] ar_addr  [2];
  logic        ar_ready [2];
  logic        r_valid  [2];
  logic [31:0] r_data   [2];
  logic [1:0]  r_resp   [2];
  logic        r_ready  [2];
  logic        ld_en    [2];
  logic [11:0] ld_addr  [2];
  logic [31:0] ld_data  [2];

  logic [31:0] model_mem [2][DEPTH];
  logic [7:0]  lfsr_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;

  axil_imem_rd_slv #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2), .RAND_LAT(0), .MAX_LAT(7)) u_fix (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(ar_valid[0]), .slv_ar_addr_i(ar_addr[0]), .slv_ar_ready_o(ar_ready[0]),
    .slv_r_valid_o(r_valid[0]), .slv_r_data_o(r_data[0]), .slv_r_resp_o(r_resp[0]),
    .slv_r_ready_i(r_ready[0]),
    .ld_en_i(ld_en[0]), .ld_addr_i(ld_addr[0]), .ld_data_i(ld_data[0])
  );

  axil_imem_rd_slv #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2), .RAND_LAT(1), .MAX_LAT(7)) u_rnd (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_ar_valid_i(ar_valid[1]), .slv_ar_addr_i(ar_addr[1]), .slv_ar_ready_o(ar_ready[1]),
    .slv_r_valid_o(r_valid[1]), .slv_r_data_o(r_data[1]), .slv_r_resp_o(r_resp[1]),
    .slv_r_ready_i(r_ready[1]),
    .ld_en_i(ld_en[1]), .ld_addr_i(ld_addr[1]), .ld_data_i(ld_data[1])
  );

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5, steps every cycle out of reset
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic void expect_rd(input int d, input logic [31:0] addr,
                                    output logic [31:0] data, output logic [1:0] resp);
    longint unsigned a = 64'(addr);
    data = 32'h0;
    if (a % 4 != 0) resp = 2'b10;
    else if (a < 64'(BASE) || a >= 64'(BASE) + 4 * 64'(DEPTH)) resp = 2'b11;
    else begin
      resp = 2'b00;
      data = model_mem[d][int'((a - 64'(BASE)) / 4)];
    end
  endfunction

  task automatic load(input int d, input int idx, input logic [31:0] val);
    ld_en[d]   = 1'b1;
    ld_addr[d] = 12'(idx);
    ld_data[d] = val;
    @(negedge clk_i);
    ld_en[d] = 1'b0;
    model_mem[d][idx] = val;
  endtask

  // Issue one read; called and returning at a negedge. hold = cycles of r_ready low after r_valid.
  task automatic read(input int d, input logic [31:0] addr, input int hold,
                      input bit ld_mid, input int ld_idx, output int lat);
    logic [31:0] ed;
    logic [1:0]  er;
    int          n;
    int          exp_lat;
    bit          got;
    lat         = 0;
    r_ready[d]  = (hold == 0);
    ar_valid[d] = 1'b1;
    ar_addr[d]  = addr;
    n = 0;
    while (!ar_ready[d] && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (ar_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL ar_accept_timeout dut=%0d addr=%h ar_ready=%b required 1", d, addr, ar_ready[d]);
      ar_valid[d] = 1'b0;
      return;
    end
    expect_rd(d, addr, ed, er);
    exp_lat = (d == 0) ? 3 : int'(lfsr_m & 8'd7) + 1;
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk_i);
      if (i == 1) ar_valid[d] = 1'b0;
      if (r_valid[d] === 1'b1) begin
        got = 1'b1;
        lat = i;
      end else begin
        checks++;
        if (ar_ready[d] !== 1'b0) begin
          errors++;
          $display("FAIL ar_ready_during_wait dut=%0d addr=%h got %b required 0", d, addr, ar_ready[d]);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL r_valid_timeout dut=%0d addr=%h no r_valid within 20 cycles", d, addr);
      return;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency dut=%0d addr=%h got %0d required %0d", d, addr, lat, exp_lat);
    end
    checks++;
    if (r_data[d] !== ed || r_resp[d] !== er) begin
      errors++;
      $display("FAIL rdata dut=%0d addr=%h got %h/%b required %h/%b", d, addr, r_data[d], r_resp[d], ed, er);
    end
    checks++;
    if (ar_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL ar_r_overlap dut=%0d addr=%h ar_ready=%b required 0", d, addr, ar_ready[d]);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && ld_mid) begin
        ld_en[d]   = 1'b1;
        ld_addr[d] = 12'(ld_idx);
        ld_data[d] = 32'h0;
      end
      @(negedge clk_i);
      if (h == 0 && ld_mid) begin
        ld_en[d] = 1'b0;
        model_mem[d][ld_idx] = 32'h0;
      end
      checks++;
      if (r_valid[d] !== 1'b1 || r_data[d] !== ed || r_resp[d] !== er || ar_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold dut=%0d cyc=%0d got v=%b d=%h r=%b ar=%b required v=1 d=%h r=%b ar=0",
                 d, h, r_valid[d], r_data[d], r_resp[d], ar_ready[d], ed, er);
      end
    end
    r_ready[d] = 1'b1;
    @(negedge clk_i);
    checks++;
    if (r_valid[d] !== 1'b0 || ar_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL after_r_hs dut=%0d got r_valid=%b ar_ready=%b required 0/1", d, r_valid[d], ar_ready[d]);
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ar_ready[d] !== 1'b0 || r_valid[d] !== 1'b0 || r_data[d] !== 32'h0 || r_resp[d] !== 2'b00) begin
          errors++;
          $display("FAIL reset_outputs dut=%0d got ar=%b v=%b d=%h r=%b required 0/0/0/00",
                   d, ar_ready[d], r_valid[d], r_data[d], r_resp[d]);
        end
      end
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ar_ready[d] !== 1'b1 || r_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut=%0d got ar_ready=%b r_valid=%b required 1/0", d, ar_ready[d], r_valid[d]);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    load(0, 0, 32'h0000_0013);
    read(0, BASE, 0, 1'b0, 0, lat);
  endtask

  task automatic test_backpressure();
    int lat;
    load(0, 1, 32'hDEAD_BEEF);
    read(0, BASE + 32'd4, 5, 1'b1, 1, lat);
    read(0, BASE + 32'd4, 0, 1'b0, 0, lat);
  endtask

  task automatic test_errors();
    int lat;
    load(0, DEPTH - 1, 32'hCAFE_F00D);
    read(0, BASE + 32'd2, 0, 1'b0, 0, lat);
    read(0, 32'h7FFF_FFFC, 1, 1'b0, 0, lat);
    read(0, BASE + 32'(4 * DEPTH), 0, 1'b0, 0, lat);
    read(0, BASE + 32'(4 * DEPTH - 4), 0, 1'b0, 0, lat);
  endtask

  task automatic test_reset_midop();
    int lat;
    ar_valid[0] = 1'b1;
    ar_addr[0]  = BASE;
    r_ready[0]  = 1'b1;
    @(negedge clk_i);
    ar_valid[0] = 1'b0;
    rst_i = 1'b0;
    #1;
    checks++;
    if (r_valid[0] !== 1'b0 || ar_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_assert got r_valid=%b ar_ready=%b required 0/0", r_valid[0], ar_ready[0]);
    end
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if (r_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL midop_reset_rvalid got %b required 0", r_valid[0]);
      end
    end
    rst_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      checks++;
      if (r_valid[0] !== 1'b0 || ar_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL midop_after_release got r_valid=%b ar_ready=%b required 0/1", r_valid[0], ar_ready[0]);
      end
    end
    read(0, BASE, 0, 1'b0, 0, lat);
  endtask

  task automatic test_back_to_back_random();
    int       lat;
    int       idx;
    int       sel;
    int       hold;
    logic [31:0] addr;
    logic [9:0]  seen = '0;
    for (int i = 0; i < 32; i++) load(1, i, $urandom);
    for (int i = 0; i < 200; i++) begin
      idx = int'($urandom_range(0, 31));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      addr = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
      else if (sel == 1) addr = BASE - 32'(4 * (idx + 1));
      else               addr = BASE + 32'(4 * idx);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      read(1, addr, hold, 1'b0, 0, lat);
      if (lat >= 1 && lat <= 8) seen[lat] = 1'b1;
    end
    checks++;
    if ($countones(seen) < 4) begin
      errors++;
      $display("FAIL distinct_latencies got %0d required >=4", $countones(seen));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ar_valid[d] = 1'b0;
      ar_addr[d]  = 32'h0;
      r_ready[d]  = 1'b0;
      ld_en[d]    = 1'b0;
      ld_addr[d]  = 12'h0;
      ld_data[d]  = 32'h0;
    end
    #2 rst_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_reset_midop();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
